axi4lite_master_cmd: RTL and testbench

- AXI4-Lite initiator (master) that turns a simple one-command-at-a-time request port into single AXI4-Lite read or write transactions.
- Used by on-FPGA sequencers and self-test logic to access register blocks built on axi4lite_interface_top, without going through the PS.
- One outstanding transaction at a time.
- Programmable timeout so a hung responder cannot lock up the sequencer.

---
 rtl/axi4lite_master_cmd_if.sv | 52 +++++
 rtl/axi4lite_master_cmd.sv | 185 ++++++++++++++++++
 tb/tb_axi4lite_master_cmd.sv | 324 ++++++++++++++++++++++++++++++++
 3 files changed

// File: rtl/axi4lite_master_cmd_if.sv
// AXI4-Lite bus bundle between the command-driven master and a register-block responder.
// AWPROT/ARPROT are carried for completeness; the master ties them to zero.
interface axi4lite_master_cmd_if #(
  parameter int ADDR_W = 11,
  parameter int DATA_W = 32
) ();
  logic [ADDR_W-1:0]   M_AXI_AWADDR;
  logic [2:0]          M_AXI_AWPROT;
  logic                M_AXI_AWVALID;
  logic                M_AXI_AWREADY;
  logic [DATA_W-1:0]   M_AXI_WDATA;
  logic [DATA_W/8-1:0] M_AXI_WSTRB;
  logic                M_AXI_WVALID;
  logic                M_AXI_WREADY;
  logic [1:0]          M_AXI_BRESP;
  logic                M_AXI_BVALID;
  logic                M_AXI_BREADY;
  logic [ADDR_W-1:0]   M_AXI_ARADDR;
  logic [2:0]          M_AXI_ARPROT;
  logic                M_AXI_ARVALID;
  logic                M_AXI_ARREADY;
  logic [DATA_W-1:0]   M_AXI_RDATA;
  logic [1:0]          M_AXI_RRESP;
  logic                M_AXI_RVALID;
  logic                M_AXI_RREADY;

  modport master (
    output M_AXI_AWADDR, M_AXI_AWPROT, M_AXI_AWVALID,
    input  M_AXI_AWREADY,
    output M_AXI_WDATA, M_AXI_WSTRB, M_AXI_WVALID,
    input  M_AXI_WREADY,
    input  M_AXI_BRESP, M_AXI_BVALID,
    output M_AXI_BREADY,
    output M_AXI_ARADDR, M_AXI_ARPROT, M_AXI_ARVALID,
    input  M_AXI_ARREADY,
    input  M_AXI_RDATA, M_AXI_RRESP, M_AXI_RVALID,
    output M_AXI_RREADY
  );

  modport slave (
    input  M_AXI_AWADDR, M_AXI_AWPROT, M_AXI_AWVALID,
    output M_AXI_AWREADY,
    input  M_AXI_WDATA, M_AXI_WSTRB, M_AXI_WVALID,
    output M_AXI_WREADY,
    output M_AXI_BRESP, M_AXI_BVALID,
    input  M_AXI_BREADY,
    input  M_AXI_ARADDR, M_AXI_ARPROT, M_AXI_ARVALID,
    output M_AXI_ARREADY,
    output M_AXI_RDATA, M_AXI_RRESP, M_AXI_RVALID,
    input  M_AXI_RREADY
  );
endinterface

// File: rtl/axi4lite_master_cmd.sv
// One-command-at-a-time AXI4-Lite master with a per-phase timeout that aborts hung transactions.
// C_M_AXI_DATA_WIDTH must be 32 or 64; TIMEOUT_CYCLES = 0 disables the timeout.
module axi4lite_master_cmd #(
  parameter int          C_M_AXI_DATA_WIDTH = 32,
  parameter int          C_M_AXI_ADDR_WIDTH = 11,
  parameter int unsigned TIMEOUT_CYCLES     = 1024
) (
  input  logic                              M_AXI_ACLK,
  input  logic                              M_AXI_ARESET,
  input  logic                              cmd_valid,
  output logic                              cmd_ready,
  input  logic                              cmd_write,
  input  logic [C_M_AXI_ADDR_WIDTH-1:0]     cmd_addr,
  input  logic [C_M_AXI_DATA_WIDTH-1:0]     cmd_wdata,
  input  logic [C_M_AXI_DATA_WIDTH/8-1:0]   cmd_wstrb,
  output logic                              rsp_valid,
  input  logic                              rsp_ready,
  output logic [C_M_AXI_DATA_WIDTH-1:0]     rsp_rdata,
  output logic [1:0]                        rsp_resp,
  output logic                              rsp_timeout,
  axi4lite_master_cmd_if.master             m_axi
);

  typedef enum logic [2:0] {
    ST_IDLE,
    ST_WR,
    ST_WR_RESP,
    ST_RD_ADDR,
    ST_RD_DATA,
    ST_RESP
  } state_t;

  localparam bit          TO_EN   = (TIMEOUT_CYCLES != 0);
  localparam logic [31:0] TO_LAST = TO_EN ? 32'(TIMEOUT_CYCLES - 1) : 32'd0;
  localparam logic [1:0]  SLVERR  = 2'b10;

  state_t                            state_q, state_d;
  logic [31:0]                       cnt_q, cnt_d;
  logic                              awvalid_q, awvalid_d;
  logic                              wvalid_q, wvalid_d;
  logic [C_M_AXI_ADDR_WIDTH-1:0]     addr_q, addr_d;
  logic [C_M_AXI_DATA_WIDTH-1:0]     wdata_q, wdata_d;
  logic [C_M_AXI_DATA_WIDTH/8-1:0]   wstrb_q, wstrb_d;
  logic [C_M_AXI_DATA_WIDTH-1:0]     rdata_q, rdata_d;
  logic [1:0]                        resp_q, resp_d;
  logic                              timeout_q, timeout_d;

  logic aw_hs, w_hs, b_hs, ar_hs, r_hs;
  logic active, timeout_hit, abort;

  // Bus outputs come only from registers or decoded state, never from READY inputs.
  assign m_axi.M_AXI_AWADDR  = addr_q;
  assign m_axi.M_AXI_AWPROT  = 3'b000;
  assign m_axi.M_AXI_AWVALID = awvalid_q;
  assign m_axi.M_AXI_WDATA   = wdata_q;
  assign m_axi.M_AXI_WSTRB   = wstrb_q;
  assign m_axi.M_AXI_WVALID  = wvalid_q;
  assign m_axi.M_AXI_BREADY  = (state_q == ST_WR_RESP);
  assign m_axi.M_AXI_ARADDR  = addr_q;
  assign m_axi.M_AXI_ARPROT  = 3'b000;
  assign m_axi.M_AXI_ARVALID = (state_q == ST_RD_ADDR);
  assign m_axi.M_AXI_RREADY  = (state_q == ST_RD_DATA);

  assign cmd_ready   = (state_q == ST_IDLE) && !M_AXI_ARESET;
  assign rsp_valid   = (state_q == ST_RESP);
  assign rsp_rdata   = rdata_q;
  assign rsp_resp    = resp_q;
  assign rsp_timeout = timeout_q;

  assign aw_hs = awvalid_q && m_axi.M_AXI_AWREADY;
  assign w_hs  = wvalid_q && m_axi.M_AXI_WREADY;
  assign b_hs  = m_axi.M_AXI_BREADY && m_axi.M_AXI_BVALID;
  assign ar_hs = m_axi.M_AXI_ARVALID && m_axi.M_AXI_ARREADY;
  assign r_hs  = m_axi.M_AXI_RREADY && m_axi.M_AXI_RVALID;

  assign active      = state_q inside {ST_WR, ST_WR_RESP, ST_RD_ADDR, ST_RD_DATA};
  assign timeout_hit = TO_EN && (cnt_q >= TO_LAST);

  always_comb begin
    // NOTE: every variable gets its default first, so no branch can infer a latch.
    state_d   = state_q;
    awvalid_d = awvalid_q;
    wvalid_d  = wvalid_q;
    addr_d    = addr_q;
    wdata_d   = wdata_q;
    wstrb_d   = wstrb_q;
    rdata_d   = rdata_q;
    resp_d    = resp_q;
    timeout_d = timeout_q;
    abort     = 1'b0;

    unique case (state_q)
      ST_IDLE: begin
        if (cmd_valid) begin
          addr_d    = cmd_addr;
          wdata_d   = cmd_wdata;
          wstrb_d   = cmd_wstrb;
          timeout_d = 1'b0;
          if (cmd_write) begin
            state_d   = ST_WR;
            awvalid_d = 1'b1;
            wvalid_d  = 1'b1;
          end else begin
            state_d = ST_RD_ADDR;
          end
        end
      end
      ST_WR: begin
        // AW and W retire independently; leave once both have handshaken.
        if (aw_hs) awvalid_d = 1'b0;
        if (w_hs)  wvalid_d  = 1'b0;
        if (!awvalid_d && !wvalid_d)           state_d = ST_WR_RESP;
        else if (timeout_hit && !aw_hs && !w_hs) abort = 1'b1;
      end
      ST_WR_RESP: begin
        if (b_hs) begin
          resp_d  = m_axi.M_AXI_BRESP;
          rdata_d = '0;
          state_d = ST_RESP;
        end else if (timeout_hit) begin
          abort = 1'b1;
        end
      end
      ST_RD_ADDR: begin
        if (ar_hs)            state_d = ST_RD_DATA;
        else if (timeout_hit) abort   = 1'b1;
      end
      ST_RD_DATA: begin
        if (r_hs) begin
          rdata_d = m_axi.M_AXI_RDATA;
          resp_d  = m_axi.M_AXI_RRESP;
          state_d = ST_RESP;
        end else if (timeout_hit) begin
          abort = 1'b1;
        end
      end
      ST_RESP: begin
        if (rsp_ready) state_d = ST_IDLE;
      end
      default: state_d = ST_IDLE;
    endcase

    // Debug-only abort: withdraws VALID, which a compliant master never does.
    if (abort) begin
      state_d   = ST_RESP;
      awvalid_d = 1'b0;
      wvalid_d  = 1'b0;
      rdata_d   = '0;
      resp_d    = SLVERR;
      timeout_d = 1'b1;
    end

    if (state_d != state_q)            cnt_d = '0;
    else if (active && (cnt_q != '1))  cnt_d = cnt_q + 32'd1;
    else                               cnt_d = cnt_q;
  end

  always_ff @(posedge M_AXI_ACLK or posedge M_AXI_ARESET) begin
    if (M_AXI_ARESET) begin
      state_q   <= ST_IDLE;
      cnt_q     <= '0;
      awvalid_q <= 1'b0;
      wvalid_q  <= 1'b0;
      addr_q    <= '0;
      wdata_q   <= '0;
      wstrb_q   <= '0;
      rdata_q   <= '0;
      resp_q    <= '0;
      timeout_q <= 1'b0;
    end else begin
      // NOTE: non-blocking assignments so every register samples pre-edge values.
      state_q   <= state_d;
      cnt_q     <= cnt_d;
      awvalid_q <= awvalid_d;
      wvalid_q  <= wvalid_d;
      addr_q    <= addr_d;
      wdata_q   <= wdata_d;
      wstrb_q   <= wstrb_d;
      rdata_q   <= rdata_d;
      resp_q    <= resp_d;
      timeout_q <= timeout_d;
    end
  end

endmodule

// File: tb/tb_axi4lite_master_cmd.sv
// Directed bench for axi4lite_master_cmd: programmable-wait responder, handshake monitor
// and a response scoreboard fed by the stimulus side.
module tb_axi4lite_master_cmd;
  localparam int DW = 32;
  localparam int AW = 11;
  localparam int TO = 16;

  logic          clk = 1'b0;
  logic          rst = 1'b1;
  logic          cmd_valid = 1'b0;
  logic          cmd_ready;
  logic          cmd_write = 1'b0;
  logic [AW-1:0] cmd_addr  = '0;
  logic [DW-1:0] cmd_wdata = '0;
  logic [DW/8-1:0] cmd_wstrb = '0;
  logic          rsp_valid;
  logic          rsp_ready = 1'b1;
  logic [DW-1:0] rsp_rdata;
  logic [1:0]    rsp_resp;
  logic          rsp_timeout;

  axi4lite_master_cmd_if #(.ADDR_W(AW), .DATA_W(DW)) bus ();

  axi4lite_master_cmd #(
    .C_M_AXI_DATA_WIDTH(DW),
    .C_M_AXI_ADDR_WIDTH(AW),
    .TIMEOUT_CYCLES(TO)
  ) dut (
    .M_AXI_ACLK   (clk),
    .M_AXI_ARESET (rst),
    .cmd_valid    (cmd_valid),
    .cmd_ready    (cmd_ready),
    .cmd_write    (cmd_write),
    .cmd_addr     (cmd_addr),
    .cmd_wdata    (cmd_wdata),
    .cmd_wstrb    (cmd_wstrb),
    .rsp_valid    (rsp_valid),
    .rsp_ready    (rsp_ready),
    .rsp_rdata    (rsp_rdata),
    .rsp_resp     (rsp_resp),
    .rsp_timeout  (rsp_timeout),
    .m_axi        (bus)
  );

  initial forever #5 clk = ~clk;

  typedef struct {
    logic [DW-1:0] rdata;
    logic [1:0]    resp;
    logic          to;
  } exp_t;
  exp_t sb[$];

  int total = 0;
  int bad   = 0;

  // Responder configuration (cycles of READY/VALID delay once the other side is waiting).
  int aw_wait = 0, w_wait = 0, ar_wait = 0, b_wait = 0, r_wait = 0;
  logic [1:0]    bresp_cfg = 2'b00;
  logic [1:0]    rresp_cfg = 2'b00;
  logic [DW-1:0] rdata_cfg = '0;

  // Monitor record, sampled just before each rising edge.
  int cyc = 0;
  int acc_cyc = 0, aw_cyc = 0, w_cyc = 0, b_cyc = 0, ar_cyc = 0, rsp_cyc = 0;
  int aw_n = 0, w_n = 0, b_n = 0, ar_n = 0, r_n = 0, rsp_n = 0;
  int awv_hi = 0, wv_hi = 0, arv_hi = 0;
  logic [AW-1:0]   aw_addr = '0, ar_addr = '0;
  logic [DW-1:0]   w_data = '0;
  logic [DW/8-1:0] w_strb = '0;

  task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s: got 0x%0h expected 0x%0h (t=%0t)", name, act, exp, $time);
    end
  endtask

  initial begin : responder
    int aw_c = 0, w_c = 0, ar_c = 0, b_c = 0, r_c = 0;
    bus.M_AXI_AWREADY = 1'b0;
    bus.M_AXI_WREADY  = 1'b0;
    bus.M_AXI_ARREADY = 1'b0;
    bus.M_AXI_BVALID  = 1'b0;
    bus.M_AXI_BRESP   = 2'b00;
    bus.M_AXI_RVALID  = 1'b0;
    bus.M_AXI_RRESP   = 2'b00;
    bus.M_AXI_RDATA   = '0;
    forever begin
      @(negedge clk);
      if (bus.M_AXI_AWVALID) begin bus.M_AXI_AWREADY = (aw_c >= aw_wait); aw_c++; end
      else begin bus.M_AXI_AWREADY = 1'b0; aw_c = 0; end
      if (bus.M_AXI_WVALID) begin bus.M_AXI_WREADY = (w_c >= w_wait); w_c++; end
      else begin bus.M_AXI_WREADY = 1'b0; w_c = 0; end
      if (bus.M_AXI_ARVALID) begin bus.M_AXI_ARREADY = (ar_c >= ar_wait); ar_c++; end
      else begin bus.M_AXI_ARREADY = 1'b0; ar_c = 0; end
      if ((aw_n > b_n) && (w_n > b_n)) begin
        bus.M_AXI_BVALID = (b_c >= b_wait);
        bus.M_AXI_BRESP  = bresp_cfg;
        b_c++;
      end else begin
        bus.M_AXI_BVALID = 1'b0;
        b_c = 0;
      end
      if (ar_n > r_n) begin
        bus.M_AXI_RVALID = (r_c >= r_wait);
        bus.M_AXI_RDATA  = rdata_cfg;
        bus.M_AXI_RRESP  = rresp_cfg;
        r_c++;
      end else begin
        bus.M_AXI_RVALID = 1'b0;
        r_c = 0;
      end
    end
  end

  initial begin : monitor
    exp_t e;
    forever begin
      @(negedge clk);
      #4;
      if (rst) begin
        // Abandon whatever the responder still owed the aborted transaction.
        w_n = aw_n;
        b_n = aw_n;
        r_n = ar_n;
      end else begin
        if (cmd_valid && cmd_ready) begin
          acc_cyc = cyc; awv_hi = 0; wv_hi = 0; arv_hi = 0;
        end
        if (bus.M_AXI_AWVALID) awv_hi++;
        if (bus.M_AXI_WVALID)  wv_hi++;
        if (bus.M_AXI_ARVALID) arv_hi++;
        if (bus.M_AXI_AWVALID && bus.M_AXI_AWREADY) begin
          aw_n++; aw_cyc = cyc; aw_addr = bus.M_AXI_AWADDR;
        end
        if (bus.M_AXI_WVALID && bus.M_AXI_WREADY) begin
          w_n++; w_cyc = cyc; w_data = bus.M_AXI_WDATA; w_strb = bus.M_AXI_WSTRB;
        end
        if (bus.M_AXI_BVALID && bus.M_AXI_BREADY) begin b_n++; b_cyc = cyc; end
        if (bus.M_AXI_ARVALID && bus.M_AXI_ARREADY) begin
          ar_n++; ar_cyc = cyc; ar_addr = bus.M_AXI_ARADDR;
        end
        if (bus.M_AXI_RVALID && bus.M_AXI_RREADY) r_n++;
        if (rsp_valid && rsp_ready) begin
          rsp_n++; rsp_cyc = cyc;
          if (sb.size() == 0) begin
            check("sb_unexpected_rsp", 64'(rsp_valid), 64'd0);
          end else begin
            e = sb.pop_front();
            check("sb_rdata",   64'(rsp_rdata),   64'(e.rdata));
            check("sb_resp",    64'(rsp_resp),    64'(e.resp));
            check("sb_timeout", 64'(rsp_timeout), 64'(e.to));
          end
        end
      end
      cyc++;
    end
  end

  task automatic do_cmd(input logic wr, input logic [AW-1:0] addr, input logic [DW-1:0] wdata,
                        input logic [DW/8-1:0] strb, input logic push,
                        input logic [DW-1:0] e_rdata, input logic [1:0] e_resp, input logic e_to);
    int n;
    exp_t e;
    if (push) begin
      e.rdata = e_rdata; e.resp = e_resp; e.to = e_to;
      sb.push_back(e);
    end
    @(negedge clk);
    cmd_valid = 1'b1; cmd_write = wr; cmd_addr = addr; cmd_wdata = wdata; cmd_wstrb = strb;
    n = 0;
    while (!cmd_ready && n < 50) begin @(negedge clk); n++; end
    check("cmd_accept_wait", 64'(n < 50), 64'd1);
    @(negedge clk);
    cmd_valid = 1'b0;
  endtask

  task automatic wait_rsp(input int start);
    int n = 0;
    while (rsp_n == start && n < 100) begin @(negedge clk); n++; end
    check("rsp_arrival_wait", 64'(rsp_n != start), 64'd1);
  endtask

  initial begin : watchdog
    #200000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin : stimulus
    int s, b0, n;
    logic [DW-1:0] hold_rdata;

    // Reset state.
    @(negedge clk);
    check("rst_cmd_ready", 64'(cmd_ready), 64'd0);
    check("rst_rsp_valid", 64'(rsp_valid), 64'd0);
    check("rst_rsp_rdata", 64'(rsp_rdata), 64'd0);
    check("rst_rsp_resp",  64'(rsp_resp),  64'd0);
    check("rst_rsp_to",    64'(rsp_timeout), 64'd0);
    check("rst_axi_hs", 64'({bus.M_AXI_AWVALID, bus.M_AXI_WVALID, bus.M_AXI_BREADY,
                               bus.M_AXI_ARVALID, bus.M_AXI_RREADY}), 64'd0);
    @(negedge clk);
    rst = 1'b0;
    @(negedge clk);
    check("idle_cmd_ready", 64'(cmd_ready), 64'd1);
    check("prot_tied", 64'({bus.M_AXI_AWPROT, bus.M_AXI_ARPROT}), 64'd0);

    // Minimum-latency write.
    s = rsp_n;
    do_cmd(1'b1, 11'h004, 32'h0000_00A5, 4'hF, 1'b1, 32'h0, 2'b00, 1'b0);
    wait_rsp(s);
    check("wr0_aw_edge", 64'(aw_cyc - acc_cyc), 64'd1);
    check("wr0_w_edge",  64'(w_cyc - acc_cyc),  64'd1);
    check("wr0_b_edge",  64'(b_cyc - acc_cyc),  64'd2);
    check("wr0_rsp_edge", 64'(rsp_cyc - acc_cyc), 64'd3);
    check("wr0_awaddr", 64'(aw_addr), 64'h004);
    check("wr0_wdata",  64'(w_data),  64'h0000_00A5);
    check("wr0_wstrb",  64'(w_strb),  64'hF);

    // Read with three AR wait cycles.
    ar_wait = 3; rdata_cfg = 32'h0000_014A;
    s = rsp_n;
    do_cmd(1'b0, 11'h004, 32'h0, 4'h0, 1'b1, 32'h0000_014A, 2'b00, 1'b0);
    wait_rsp(s);
    check("rd0_ar_edge", 64'(ar_cyc - acc_cyc), 64'd4);
    check("rd0_arvalid_cycles", 64'(arv_hi), 64'd4);
    check("rd0_araddr", 64'(ar_addr), 64'h004);
    ar_wait = 0;

    // W completes two cycles before AW.
    aw_wait = 2; w_wait = 0;
    s = rsp_n; b0 = b_n;
    do_cmd(1'b1, 11'h008, 32'h1234_5678, 4'h3, 1'b1, 32'h0, 2'b00, 1'b0);
    wait_rsp(s);
    check("wr1_w_edge",  64'(w_cyc - acc_cyc),  64'd1);
    check("wr1_aw_edge", 64'(aw_cyc - acc_cyc), 64'd3);
    check("wr1_awvalid_cycles", 64'(awv_hi), 64'd3);
    check("wr1_wvalid_cycles",  64'(wv_hi),  64'd1);
    check("wr1_b_count", 64'(b_n - b0), 64'd1);
    check("wr1_wstrb", 64'(w_strb), 64'h3);

    // AW completes two cycles before W.
    aw_wait = 0; w_wait = 2;
    s = rsp_n; b0 = b_n;
    do_cmd(1'b1, 11'h00C, 32'hCAFE_0001, 4'hC, 1'b1, 32'h0, 2'b00, 1'b0);
    wait_rsp(s);
    check("wr2_aw_edge", 64'(aw_cyc - acc_cyc), 64'd1);
    check("wr2_w_edge",  64'(w_cyc - acc_cyc),  64'd3);
    check("wr2_awvalid_cycles", 64'(awv_hi), 64'd1);
    check("wr2_wvalid_cycles",  64'(wv_hi),  64'd3);
    check("wr2_b_count", 64'(b_n - b0), 64'd1);
    check("wr2_rsp_edge", 64'(rsp_cyc - acc_cyc), 64'd5);
    w_wait = 0;

    // Responder never accepts AR: timeout after TO cycles of ARVALID.
    ar_wait = 1000;
    s = rsp_n;
    do_cmd(1'b0, 11'h7FC, 32'h0, 4'h0, 1'b1, 32'h0, 2'b10, 1'b1);
    wait_rsp(s);
    check("to_arvalid_cycles", 64'(arv_hi), 64'd16);
    check("to_rsp_edge", 64'(rsp_cyc - acc_cyc), 64'd17);
    check("to_arvalid_low", 64'(bus.M_AXI_ARVALID), 64'd0);
    check("to_cmd_ready_back", 64'(cmd_ready), 64'd1);
    check("to_flag_held", 64'(rsp_timeout), 64'd1);
    ar_wait = 0;

    // Response held off for five cycles; responder returns SLVERR.
    rsp_ready = 1'b0; bresp_cfg = 2'b10;
    s = rsp_n;
    do_cmd(1'b1, 11'h010, 32'h0000_00FF, 4'h1, 1'b1, 32'h0, 2'b10, 1'b0);
    check("to_flag_cleared", 64'(rsp_timeout), 64'd0);
    n = 0;
    while (!rsp_valid && n < 50) begin @(negedge clk); n++; end
    check("hold_rsp_wait", 64'(rsp_valid), 64'd1);
    hold_rdata = rsp_rdata;
    for (int i = 0; i < 5; i++) begin
      check("hold_rsp_valid", 64'(rsp_valid), 64'd1);
      check("hold_rsp_resp",  64'(rsp_resp),  64'h2);
      check("hold_rsp_rdata", 64'(rsp_rdata), 64'(hold_rdata));
      check("hold_rsp_to",    64'(rsp_timeout), 64'd0);
      check("hold_cmd_ready", 64'(cmd_ready), 64'd0);
      @(negedge clk);
    end
    rsp_ready = 1'b1; bresp_cfg = 2'b00;
    wait_rsp(s);

    // Reset pulsed while waiting for B: no response for that command.
    b_wait = 1000;
    s = rsp_n;
    do_cmd(1'b1, 11'h020, 32'hBAD0_BAD0, 4'hF, 1'b0, 32'h0, 2'b00, 1'b0);
    n = 0;
    while (!bus.M_AXI_BREADY && n < 50) begin @(negedge clk); n++; end
    check("rst_mid_in_wr_resp", 64'(bus.M_AXI_BREADY), 64'd1);
    #2 rst = 1'b1;
    #1;
    check("rst_mid_axi", 64'({bus.M_AXI_AWVALID, bus.M_AXI_WVALID, bus.M_AXI_BREADY,
                                bus.M_AXI_ARVALID, bus.M_AXI_RREADY}), 64'd0);
    check("rst_mid_cmd_ready", 64'(cmd_ready), 64'd0);
    check("rst_mid_rsp_valid", 64'(rsp_valid), 64'd0);
    @(negedge clk);
    @(negedge clk);
    rst = 1'b0; b_wait = 0;
    @(negedge clk);
    @(negedge clk);
    check("rst_mid_no_rsp", 64'(rsp_n - s), 64'd0);

    // Normal read after reset release.
    rdata_cfg = 32'hDEAD_BEEF; rresp_cfg = 2'b00;
    s = rsp_n;
    do_cmd(1'b0, 11'h030, 32'h0, 4'h0, 1'b1, 32'hDEAD_BEEF, 2'b00, 1'b0);
    wait_rsp(s);
    check("post_rst_araddr", 64'(ar_addr), 64'h030);
    check("post_rst_rsp_edge", 64'(rsp_cyc - acc_cyc), 64'd3);

    repeat (3) @(negedge clk);
    check("sb_drained", 64'(sb.size()), 64'd0);
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
